// File: rtl/data_cache_controller.sv
// data_cache_controller: 2-way set-associative, write-through, no-write-allocate data cache
// between the MEM stage and the SRAM controller. Define CACHE_STATS_EN for read hit/miss counters.
module data_cache_controller #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 11,
  parameter int unsigned BASE    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        sram_wrEn,
  output logic        sram_rdEn,
  output logic [31:0] sram_address,
  output logic [31:0] sram_writeData,
  input  logic [31:0] sram_readData,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int unsigned WA_W = INDEX_W + TAG_W;
  localparam int unsigned SETS = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WRITE} state_e;

  state_e             state_q, state_d;

  logic [SETS-1:0]    valid_q [2];
  logic [TAG_W-1:0]   tag_q   [2][SETS];
  logic [31:0]        data_q  [2][SETS];
  logic [SETS-1:0]    lru_q;

  logic [31:0]        offset;
  logic [WA_W-1:0]    wa;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               unused_addr;

  logic               match0, match1, hit, hit_way, victim;
  logic [31:0]        hit_data;

  logic               wr_hit_en, fill_en, touch_en, touch_way;

  // Word address relative to the data-memory base, split into set index and tag.
  assign offset      = address - 32'(BASE);
  assign wa          = offset[WA_W+1:2];
  assign idx         = wa[INDEX_W-1:0];
  assign tag         = wa[WA_W-1:INDEX_W];
  assign unused_addr = ^{offset[31:WA_W+2], offset[1:0]};

  assign match0   = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign match1   = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit      = match0 | match1;
  assign hit_way  = ~match0;
  assign hit_data = data_q[hit_way][idx];

  // Fill an empty way first; only evict the LRU way when both are valid.
  assign victim = !valid_q[0][idx] ? 1'b0 :
                  (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

  assign sram_rdEn      = (state_q == RD_MISS);
  assign sram_wrEn      = (state_q == WRITE);
  assign sram_address   = address;
  assign sram_writeData = writeData;

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    readData  = '0;
    wr_hit_en = 1'b0;
    fill_en   = 1'b0;
    touch_en  = 1'b0;
    touch_way = hit_way;
    case (state_q)
      IDLE: begin
        if (wrEn) begin
          state_d   = WRITE;
          wr_hit_en = hit;
          touch_en  = hit;
        end else if (rdEn) begin
          if (hit) begin
            ready    = 1'b1;
            readData = hit_data;
            touch_en = 1'b1;
          end else begin
            state_d = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        if (sram_ready) begin
          ready     = 1'b1;
          readData  = sram_readData;
          fill_en   = 1'b1;
          touch_en  = 1'b1;
          touch_way = victim;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      state_q <= state_d;
      if (wr_hit_en) begin
        data_q[hit_way][idx] <= writeData;
      end
      if (fill_en) begin
        valid_q[victim][idx] <= 1'b1;
        tag_q[victim][idx]   <= tag;
        data_q[victim][idx]  <= sram_readData;
      end
      if (touch_en) begin
        lru_q[idx] <= ~touch_way;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        rd_hit_done;

  assign rd_hit_done = (state_q == IDLE) && !wrEn && rdEn && hit;

  // Saturating counters of completed reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit_done && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (fill_en && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Bench for data_cache_controller: directed table, reset/abort sequences and randomized
// accesses against a recency-queue cache model and a latency-programmable SRAM model.
module tb_data_cache_controller;

  logic        clk;
  logic        rst;
  logic        wrEn, rdEn;
  logic [31:0] address, writeData;
  logic [31:0] readData;
  logic        ready;
  logic        sram_wrEn, sram_rdEn;
  logic [31:0] sram_address, sram_writeData;
  logic [31:0] sram_readData = '0;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  data_cache_controller dut (
    .clk            (clk),
    .rst            (rst),
    .wrEn           (wrEn),
    .rdEn           (rdEn),
    .address        (address),
    .writeData      (writeData),
    .readData       (readData),
    .ready          (ready),
    .sram_wrEn      (sram_wrEn),
    .sram_rdEn      (sram_rdEn),
    .sram_address   (sram_address),
    .sram_writeData (sram_writeData),
    .sram_readData  (sram_readData),
    .sram_ready     (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial SRAM contents.
  function automatic logic [31:0] mem_init(input logic [31:0] a);
    case (a)
      32'd1024: return 32'hDEADBEEF;
      32'd1280: return 32'h1280_1280;
      32'd1536: return 32'h1536_1536;
      default:  return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // SRAM controller model: ready pulses in the lat-th cycle of a request.
  int unsigned lat = 5;
  int unsigned cnt = 0;
  logic        model_rdy = 1'b0;
  logic        spurious_rdy = 1'b0;
  logic [31:0] sram_mem [logic [31:0]];

  assign sram_ready = model_rdy | spurious_rdy;

  always @(posedge clk) begin
    #1;
    if (model_rdy || rst) begin
      model_rdy = 1'b0;
      cnt = 0;
    end else if (sram_rdEn || sram_wrEn) begin
      cnt++;
      if (cnt >= lat) begin
        model_rdy = 1'b1;
        if (sram_wrEn) sram_mem[sram_address] = sram_writeData;
        else sram_readData = sram_mem.exists(sram_address) ? sram_mem[sram_address]
                                                           : mem_init(sram_address);
      end
    end else begin
      cnt = 0;
    end
  end

  // Reference: memory image plus one recency queue of cached word addresses (front = MRU).
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rq [$];

  function automatic int set_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) >> 2;
    return int'(w[5:0]);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic bit ref_access(input logic [31:0] a, input bit fill);
    int pos = -1;
    int n = 0;
    int last = -1;
    for (int i = 0; i < rq.size(); i++) if (rq[i] == a && pos < 0) pos = i;
    if (pos >= 0) begin
      rq.delete(pos);
      rq.push_front(a);
      return 1'b1;
    end
    if (fill) begin
      for (int i = 0; i < rq.size(); i++) begin
        if (set_of(rq[i]) == set_of(a)) begin
          n++;
          last = i;
        end
      end
      if (n >= 2) rq.delete(last);
      rq.push_front(a);
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One MEM-stage access, held until ready; reports stall cycles and SRAM-active cycles.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input int unsigned l,
                        output int stall, output int sram_cyc,
                        output logic [31:0] rdata, output bit mirror_ok);
    bit done;
    @(posedge clk); #2;
    lat = l;
    wrEn = wr; rdEn = rd; address = addr; writeData = wdata;
    stall = 0; sram_cyc = 0; rdata = '0; mirror_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (sram_rdEn || sram_wrEn) begin
        sram_cyc++;
        if (sram_address !== addr || sram_writeData !== wdata) mirror_ok = 1'b0;
      end
      if (ready) begin
        rdata = readData;
        done = 1'b1;
        break;
      end
      stall++;
      @(posedge clk);
    end
    if (!done) chk("access_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    @(posedge clk); #2;
    wrEn = 1'b0; rdEn = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    rq.delete();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [13];

  initial begin : main
    int stall, sc;
    logic [31:0] rd;
    bit mok, hit, wr, rdq;
    int k, op;
    logic [31:0] a, d;
    int unsigned l;
    int wait_n;

    vt[0]  = '{1'b0, 32'd1024, 32'h0,        5, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 32'd1024, 32'h0,        0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'd1024, 32'h12345678, 5, 32'h0};
    vt[3]  = '{1'b0, 32'd1024, 32'h0,        0, 32'h12345678};
    vt[4]  = '{1'b0, 32'd1280, 32'h0,        5, 32'h1280_1280};
    vt[5]  = '{1'b0, 32'd1024, 32'h0,        0, 32'h12345678};
    vt[6]  = '{1'b0, 32'd1536, 32'h0,        5, 32'h1536_1536};
    vt[7]  = '{1'b0, 32'd1024, 32'h0,        0, 32'h12345678};
    vt[8]  = '{1'b0, 32'd1280, 32'h0,        5, 32'h1280_1280};
    vt[9]  = '{1'b1, 32'd1792, 32'hCAFEF00D, 5, 32'h0};
    vt[10] = '{1'b0, 32'd1792, 32'h0,        5, 32'hCAFEF00D};
    vt[11] = '{1'b0, 32'd1280, 32'h0,        0, 32'h1280_1280};
    vt[12] = '{1'b0, 32'd1024, 32'h0,        5, 32'h12345678};

    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; address = 32'd1024; writeData = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_sram_rdEn", 32'(sram_rdEn), 32'd0);
    chk("reset_sram_wrEn", 32'(sram_wrEn), 32'd0);
    chk("reset_readData", readData, 32'd0);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      access(vt[i].wr, !vt[i].wr, vt[i].addr, vt[i].wdata, 5, stall, sc, rd, mok);
      if (vt[i].wr) ref_mem[vt[i].addr] = vt[i].wdata;
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].exp_stall));
      chk($sformatf("vec%0d_sram_cycles", i), 32'(sc), 32'(vt[i].exp_stall));
      chk($sformatf("vec%0d_mirror", i), 32'(mok), 32'd1);
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
    end
    // Request must drop the cycle after sram_ready.
    idle();
    @(negedge clk);
    chk("req_drop_rdEn", 32'(sram_rdEn), 32'd0);
    chk("req_drop_ready", 32'(ready), 32'd1);

    // Reset in the middle of a read miss.
    @(posedge clk); #2; lat = 5; rdEn = 1'b1; address = 32'd2048;
    @(negedge clk); chk("miss_idle_ready", 32'(ready), 32'd0);
    @(posedge clk); #2;
    @(negedge clk); chk("rdmiss_sram_rdEn", 32'(sram_rdEn), 32'd1);
    chk("rdmiss_ready", 32'(ready), 32'd0);
    @(posedge clk); #2; rst = 1'b1; rdEn = 1'b0;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("rdabort_sram_rdEn", 32'(sram_rdEn), 32'd0);
    chk("rdabort_ready", 32'(ready), 32'd1);
    chk("rdabort_readData", readData, 32'd0);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 5, stall, sc, rd, mok);
    chk("after_reset_miss_stall", 32'(stall), 32'd5);
    chk("after_reset_miss_data", rd, 32'h12345678);

    // Reset in the middle of a write: no SRAM commit.
    @(posedge clk); #2; wrEn = 1'b1; rdEn = 1'b0; address = 32'd2048; writeData = 32'hBAD0_0001;
    @(posedge clk); #2;
    @(negedge clk); chk("write_sram_wrEn", 32'(sram_wrEn), 32'd1);
    chk("write_ready", 32'(ready), 32'd0);
    @(posedge clk); #2; rst = 1'b1; wrEn = 1'b0;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("wrabort_sram_wrEn", 32'(sram_wrEn), 32'd0);
    chk("wrabort_ready", 32'(ready), 32'd1);

    // sram_ready seen in IDLE must not complete a miss.
    @(posedge clk); #2; spurious_rdy = 1'b1; rdEn = 1'b1; address = 32'd2048;
    @(negedge clk);
    chk("idle_rdy_ignored_ready", 32'(ready), 32'd0);
    chk("idle_rdy_ignored_data", readData, 32'd0);
    @(posedge clk); #2; spurious_rdy = 1'b0;
    wait_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) break;
      wait_n++;
      @(posedge clk);
    end
    chk("idle_rdy_miss_cycles", 32'(wait_n), 32'd4);
    chk("idle_rdy_miss_data", readData, mem_init(32'd2048));
    idle();

    // Randomized accesses against the reference model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      k  = int'($urandom_range(0, 7));
      a  = 32'd1024 + 32'(((k >> 1) * 64 + (k & 1)) * 4);
      op = int'($urandom_range(0, 9));
      l  = $urandom_range(1, 4);
      d  = $urandom;
      wr = (op <= 3);
      rdq = (op >= 3);
      access(wr, rdq, a, d, l, stall, sc, rd, mok);
      if (wr) begin
        hit = ref_access(a, 1'b0);
        ref_mem[a] = d;
        chk($sformatf("rand%0d_wr_stall", i), 32'(stall), 32'(l));
        chk($sformatf("rand%0d_wr_sram", i), 32'(sc), 32'(l));
      end else begin
        hit = ref_access(a, 1'b1);
        chk($sformatf("rand%0d_rd_stall", i), 32'(stall), hit ? 32'd0 : 32'(l));
        chk($sformatf("rand%0d_rd_sram", i), 32'(sc), hit ? 32'd0 : 32'(l));
        chk($sformatf("rand%0d_rd_data", i), rd, exp_read(a));
      end
      chk($sformatf("rand%0d_mirror", i), 32'(mok), 32'd1);
    end
    idle();

`ifdef CACHE_STATS_EN
    do_reset();
    access(1'b0, 1'b1, 32'd1024, 32'h0, 5, stall, sc, rd, mok);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 5, stall, sc, rd, mok);
    idle();
    @(negedge clk);
    chk("stats_hit_count", 32'(hit_count), 32'd1);
    chk("stats_miss_count", 32'(miss_count), 32'd1);
    @(posedge clk); #2; rdEn = 1'b1; address = 32'd1024;
    repeat (65536) @(posedge clk);
    #2 rdEn = 1'b0;
    @(negedge clk);
    chk("stats_hit_saturate", 32'(hit_count), 32'h0000FFFF);
    chk("stats_miss_after_hits", 32'(miss_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
